// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Conditioning stage for active-low board push-buttons. Each key channel
//   has a two-flop synchronizer, a stability counter and a two-state
//   (UP/DOWN) acceptance FSM. It produces a clean level and one-cycle
//   press/release pulses.
//
//   Optional long-press detector: define KEY_DEBOUNCER_LONG_PRESS_EN to build
//   a per-channel hold timer. This timer emits one key_long pulse
//   LONG_PRESS_COUNT cycles after the key_press pulse. Without the macro,
//   key_long is tied to 0 and no hold timer exists.
//
//   Every output comes from a register, so there is no combinational path
//   from KEY to any output.
// -----------------------------------------------------------------------------

// One debounce channel. It sees only the synchronized pin (0 = pressed).
module key_debouncer_channel #(
    parameter int DEBOUNCE_COUNT   = 1_000_000,
    parameter int LONG_PRESS_COUNT = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic press,
    output logic lift,
    output logic held
);

    // The stability counter only needs to reach DEBOUNCE_COUNT-1. It clears
    // on that value, so it never wraps.
    localparam int                 CNT_W    = $clog2(DEBOUNCE_COUNT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

    // A legal configuration needs a window of at least two cycles and a
    // long-press time beyond the debounce time.
    localparam bit CFG_OK = (DEBOUNCE_COUNT >= 2) && (LONG_PRESS_COUNT > DEBOUNCE_COUNT);

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             accept;

    // A mismatch means the synchronized pin disagrees with the accepted
    // state: pin low while UP, or pin high while DOWN.
    assign mismatch = (state == UP) ? ~pin : pin;

    // The change is accepted when the last cycle of the window still
    // disagrees with the accepted state.
    assign accept   = mismatch && (cnt == CNT_LAST);

    // DOWN is a register, so level is glitch-free.
    assign level    = (state == DOWN);

    // Acceptance FSM, stability counter and press/release event registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= UP;
            cnt   <= '0;
            press <= 1'b0;
            lift  <= 1'b0;
        end else begin
            // Events default low, so each pulse lasts exactly one cycle.
            press <= 1'b0;
            lift  <= 1'b0;
            if (mismatch) begin
                if (accept) begin
                    cnt <= '0;
                    if (state == UP) begin
                        state <= DOWN;
                        press <= 1'b1;
                    end else begin
                        state <= UP;
                        lift  <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                // Agreement, even for one cycle, restarts the window.
                // Bounce therefore never accumulates.
                cnt <= '0;
            end
        end
    end

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
    localparam int                  HOLD_W    = $clog2(LONG_PRESS_COUNT + 1);
    localparam logic [HOLD_W-1:0]   HOLD_MAX  = HOLD_W'(LONG_PRESS_COUNT);
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(LONG_PRESS_COUNT - 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Hold timer: counts cycles spent in DOWN and saturates at the limit.
    // It fires once when it reaches the limit, so a long press gives one
    // pulse with no repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            held     <= 1'b0;
        end else begin
            held <= 1'b0;
            // Stay-in-DOWN cycles only. The entry edge and the release edge
            // both leave the timer at 0.
            if ((state == DOWN) && !accept) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                    held     <= (hold_cnt == HOLD_LAST);
                end
            end else begin
                hold_cnt <= '0;
            end
        end
    end
`else
    assign held = 1'b0;
`endif

    // Runtime guards: the configuration must be legal, and press and release
    // must never coincide.
    a_cfg_ok: assert property (@(posedge clk) CFG_OK);
    a_press_xor_lift: assert property (@(posedge clk) disable iff (!rst_n) !(press && lift));

endmodule

// Top level: synchronizes the raw pins and instantiates one channel per key.
module key_debouncer #(
    parameter int NUM_KEYS         = 2,
    parameter int DEBOUNCE_COUNT   = 1_000_000,
    parameter int LONG_PRESS_COUNT = 50_000_000
) (
    input  logic                FPGA_CLK1_50,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_key;

    // Two-flop synchronizer. Both stages reset to 1 (released), so a held
    // key after reset goes through the full debounce window.
    always_ff @(posedge FPGA_CLK1_50 or negedge rst) begin
        if (!rst) begin
            sync_meta <= '1;
            sync_key  <= '1;
        end else begin
            // NOTE: non-blocking assignments make the two stages shift
            // together. With blocking assignments, sync_key would take KEY
            // in the same edge and the synchronizer would collapse to one
            // flop.
            sync_meta <= KEY;
            sync_key  <= sync_meta;
        end
    end

    // Fully independent channels. Events on several keys in the same cycle
    // are all reported in that cycle.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
        key_debouncer_channel #(
            .DEBOUNCE_COUNT  (DEBOUNCE_COUNT),
            .LONG_PRESS_COUNT(LONG_PRESS_COUNT)
        ) u_chan (
            .clk  (FPGA_CLK1_50),
            .rst_n(rst),
            .pin  (sync_key[i]),
            .level(key_level[i]),
            .press(key_press[i]),
            .lift (key_release[i]),
            .held (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//   The reference model works from sample history. The raw pin is delayed
//   two edges, and a change is accepted when the last DB delayed samples all
//   disagree with the accepted level. A long press is detected from the
//   press time stamp. Directed scenarios add literal expectations, followed
//   by randomized key activity with occasional resets.
//   Honours KEY_DEBOUNCER_LONG_PRESS_EN to match the DUT build.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int NK = 2;
    localparam int DB = 4;
    localparam int LP = 20;

`ifdef KEY_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key;
    logic [NK-1:0] key_level, key_press, key_release, key_long;

    int n_total = 0;
    int n_pass  = 0;

    key_debouncer #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_COUNT  (DB),
        .LONG_PRESS_COUNT(LP)
    ) dut (
        .FPGA_CLK1_50(clk),
        .rst         (rst_n),
        .KEY         (key),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- behavioural reference model ----------------
    bit            pipe0 [NK];
    bit            pipe1 [NK];
    bit            hist  [NK][DB-1];   // earlier samples seen by the FSM, 1 = pressed
    logic [NK-1:0] m_level, m_press, m_release, m_long;
    int            cyc = 0;
    int            press_cyc [NK];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < NK; i++) begin
                pipe0[i]     <= 1'b1;
                pipe1[i]     <= 1'b1;
                press_cyc[i] <= 0;
                for (int j = 0; j < DB - 1; j++) hist[i][j] <= 1'b0;
            end
            m_level   <= '0;
            m_press   <= '0;
            m_release <= '0;
            m_long    <= '0;
        end else begin
            for (int i = 0; i < NK; i++) begin
                bit seen;
                bit all_opp;
                seen    = !pipe1[i];
                all_opp = (seen != m_level[i]);
                for (int j = 0; j < DB - 1; j++)
                    if (hist[i][j] == m_level[i]) all_opp = 1'b0;
                pipe1[i]   <= pipe0[i];
                pipe0[i]   <= key[i];
                hist[i][0] <= seen;
                for (int j = 1; j < DB - 1; j++) hist[i][j] <= hist[i][j-1];
                m_press[i]   <= 1'b0;
                m_release[i] <= 1'b0;
                m_long[i]    <= 1'b0;
                if (all_opp) begin
                    m_level[i] <= !m_level[i];
                    if (!m_level[i]) begin
                        m_press[i]   <= 1'b1;
                        press_cyc[i] <= cyc;
                    end else begin
                        m_release[i] <= 1'b1;
                    end
                end else if (m_level[i] && (cyc - press_cyc[i] == LP)) begin
                    m_long[i] <= LONG_EN;
                end
            end
        end
    end

    // Compare every cycle, away from the clock edge.
    always @(posedge clk) begin
        #1;
        check("cmp_level",   32'(key_level),   32'(m_level));
        check("cmp_press",   32'(key_press),   32'(m_press));
        check("cmp_release", 32'(key_release), 32'(m_release));
        check("cmp_long",    32'(key_long),    32'(m_long));
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    // ---------------- directed scenarios + random ----------------
    initial begin
        int found;
        int cnt;
        int hold_left [NK];

        rst_n = 1'b0;
        key   = '1;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // 1: idle after reset, no pulses, levels low
        for (int k = 0; k < 50; k++) begin
            tick();
            check("s1_idle", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        end

        // 2: hold KEY[0] low -> accepted on the 6th edge
        key[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("s2_wait_level", 32'(key_level), 32'd0);
        end
        tick();
        check("s2_level", 32'(key_level), 32'b01);
        check("s2_press", 32'(key_press), 32'b01);
        tick();
        check("s2_press_width", 32'(key_press), 32'd0);
        check("s2_level_hold",  32'(key_level), 32'b01);

        // 3: glitches of 3 cycles are rejected, then a stable low is accepted
        key[0] = 1'b1;
        tick(10);
        check("s3_released", 32'(key_level[0]), 32'd0);
        cnt = 0;
        for (int g = 0; g < 4; g++) begin
            key[0] = (g % 2 == 1);
            for (int k = 0; k < 3; k++) begin
                tick();
                cnt += int'(key_press[0]);
            end
        end
        key[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            cnt += int'(key_press[0]);
        end
        check("s3_no_glitch_press", 32'(cnt), 32'd0);
        tick();
        check("s3_press", 32'(key_press[0]), 32'd1);

        // 4: long press on KEY[1], one pulse only
        key[0] = 1'b1;
        tick(10);
        key[1] = 1'b0;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            tick();
            if (key_press[1]) found = k;
        end
        check("s4_press_latency", 32'(found), 32'd6);
        cnt = 0;
        for (int t = 1; t < LP; t++) begin
            tick();
            cnt += int'(key_long[1]);
        end
        check("s4_no_early_long", 32'(cnt), 32'd0);
        tick();
        check("s4_long", 32'(key_long[1]), 32'(LONG_EN));
        cnt = 0;
        for (int t = 0; t < 100; t++) begin
            tick();
            cnt += int'(key_long[1]);
        end
        check("s4_no_repeat", 32'(cnt), 32'd0);
        key[1] = 1'b1;
        tick(10);

        // 5: short press on KEY[0], release after 10 accepted cycles
        key[0] = 1'b0;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            tick();
            if (key_press[0]) found = k;
        end
        check("s5_press_latency", 32'(found), 32'd6);
        tick(10);
        key[0] = 1'b1;
        found = 0;
        cnt   = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            cnt += int'(key_long[0]);
            if (key_release[0] && found == 0) found = k;
        end
        check("s5_release_latency", 32'(found), 32'd6);
        check("s5_no_long", 32'(cnt), 32'd0);

        // 6a: reset mid-debounce (cnt = 2)
        key[0] = 1'b0;
        tick(4);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("s6_reset_debounce", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            tick();
            if (key_press[0]) found = k;
        end
        check("s6_press_after_reset", 32'(found), 32'd6);

        // 6b: reset mid-hold
        tick(10);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("s6_reset_hold", 32'({key_level, key_press, key_release, key_long}), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 10 && found == 0; k++) begin
            tick();
            if (key_press[0]) found = k;
        end
        check("s6_press_after_hold_reset", 32'(found), 32'd6);
        tick(LP);
        check("s6_long_after_reset", 32'(key_long[0]), 32'(LONG_EN));

        // Random activity: short bounces, real presses and occasional long holds
        for (int i = 0; i < NK; i++) hold_left[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold_left[i] == 0) begin
                    key[i]       = 1'($urandom_range(0, 1));
                    hold_left[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40))
                                                               : int'($urandom_range(1, 8));
                end
                hold_left[i]--;
            end
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk) rst_n = 1'b0;
                @(negedge clk) rst_n = 1'b1;
            end
            tick();
        end

        key = '1;
        tick(10);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
